mitchell_decoder: RTL and testbench

//  Antilog (decode) end of the Mitchell log-multiplier datapath. Takes a log-domain value
//  {integer k, fraction f}, normally the sum of two mitchell_encoder outputs from the

---
 rtl/mitchell_decoder_pkg.sv | 16 +
 rtl/mitchell_decoder_shift.sv | 46 ++++
 rtl/mitchell_decoder.sv | 64 ++++++
 tb/tb_mitchell_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mitchell_decoder_pkg.sv
// Shared Mitchell log-multiplier constants and the decoder's stage-1 payload.
package mitchell_decoder_pkg;

  localparam int MITCHELL_INT_W  = 4;
  localparam int MITCHELL_FRAC_W = 7;
  localparam int MITCHELL_OUT_W  = 16;
  localparam int MITCHELL_LOG_W  = MITCHELL_INT_W + MITCHELL_FRAC_W;

  // Log-domain beat captured by stage 1.
  typedef struct packed {
    logic [MITCHELL_INT_W-1:0]  k;
    logic [MITCHELL_FRAC_W-1:0] f;
    logic                       zero;
  } s1_t;

endpackage

// File: rtl/mitchell_decoder_shift.sv
// Combinational antilog: (k, f, zero) -> (1.f) * 2^k.
// Optional MITCHELL_DEC_ROUND_EN: round half-up on right shifts, saturate to all ones.
module mitchell_antilog_shift
  import mitchell_decoder_pkg::*;
(
  input  logic [MITCHELL_INT_W-1:0]  k,
  input  logic [MITCHELL_FRAC_W-1:0] f,
  input  logic                       zero,
  output logic [MITCHELL_OUT_W-1:0]  prod
);

  // Mantissa placed at binary point FRAC_W and shifted left by k; the upper
  // OUT_W bits are the integer product, the lower FRAC_W bits are what a
  // right shift would discard (all zero when k >= FRAC_W).
  localparam int WIDE_W = MITCHELL_OUT_W + MITCHELL_FRAC_W;

  logic [WIDE_W-1:0] wide;

  assign wide = WIDE_W'({1'b1, f}) << k;

`ifdef MITCHELL_DEC_ROUND_EN
  logic [MITCHELL_OUT_W:0] rnd;
  logic [MITCHELL_FRAC_W-2:0] unused_low;

  assign unused_low = wide[MITCHELL_FRAC_W-2:0];
  assign rnd = {1'b0, wide[WIDE_W-1:MITCHELL_FRAC_W]}
             + (MITCHELL_OUT_W+1)'(wide[MITCHELL_FRAC_W-1]);

  // First discarded bit rounds up; a carry out of OUT_W clamps to max.
  always_comb begin
    prod = '0;
    if (!zero) prod = rnd[MITCHELL_OUT_W] ? '1 : rnd[MITCHELL_OUT_W-1:0];
  end
`else
  logic [MITCHELL_FRAC_W-1:0] unused_low;

  assign unused_low = wide[MITCHELL_FRAC_W-1:0];

  // Pure truncation: discarded fraction bits are dropped.
  always_comb begin
    prod = '0;
    if (!zero) prod = wide[WIDE_W-1:MITCHELL_FRAC_W];
  end
`endif

endmodule

// File: rtl/mitchell_decoder.sv
// Mitchell antilog decoder: two-stage valid/ready pipeline around mitchell_antilog_shift.
// Build option: MITCHELL_DEC_ROUND_EN enables rounding/saturation in the shifter.
module mitchell_decoder
  import mitchell_decoder_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MITCHELL_LOG_W-1:0] in_log,
  input  logic                      in_zero,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [MITCHELL_OUT_W-1:0] out_prod,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int STAGES = 2;

  logic [STAGES:1]          vld_pipe;
  s1_t                      s1;
  logic                     adv1, adv2;
  logic [MITCHELL_OUT_W-1:0] shift_prod;

  // A stage advances when it is empty or the stage after it is advancing;
  // in_ready is the stage-1 condition directly (no skid buffer).
  always_comb begin
    adv2 = !vld_pipe[2] || out_ready;
    adv1 = !vld_pipe[1] || adv2;
  end

  assign in_ready  = adv1;
  assign out_valid = vld_pipe[2];

  mitchell_antilog_shift u_shift (
    .k    (s1.k),
    .f    (s1.f),
    .zero (s1.zero),
    .prod (shift_prod)
  );

  // Stage 1 captures the log beat, stage 2 captures the decoded product;
  // out_prod only changes on a stage-2 load so it holds through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      out_prod <= '0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1.k    <= in_log[MITCHELL_LOG_W-1:MITCHELL_FRAC_W];
          s1.f    <= in_log[MITCHELL_FRAC_W-1:0];
          s1.zero <= in_zero;
        end
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) out_prod <= shift_prod;
      end
    end
  end

endmodule

// File: tb/tb_mitchell_decoder.sv
// Self-checking bench for mitchell_decoder: directed cases, stall, reset, random stream.
module tb_mitchell_decoder;
  import mitchell_decoder_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [MITCHELL_LOG_W-1:0] in_log = '0;
  logic                      in_zero = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [MITCHELL_OUT_W-1:0] out_prod;
  logic                      out_valid;
  logic                      out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int pops  = 0;
  bit rand_rdy = 1'b0;
  logic [MITCHELL_OUT_W-1:0] exp_q[$];
  bit held_vld = 1'b0;
  logic [MITCHELL_OUT_W-1:0] held;

  mitchell_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_log    (in_log),
    .in_zero   (in_zero),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_prod  (out_prod),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference: exact value (1 + f/2^FRAC_W) * 2^k, floored (or rounded half-up and clamped).
  function automatic logic [MITCHELL_OUT_W-1:0] ref_prod(int k, int f, bit z);
    longint scale, p, q;
    if (z) return '0;
    scale = longint'(1) << MITCHELL_FRAC_W;
    p = (scale + longint'(f)) << k;
    q = p / scale;
`ifdef MITCHELL_DEC_ROUND_EN
    if ((p % scale) * 2 >= scale) q = q + 1;
    if (q > 65535) q = 65535;
`endif
    return q[MITCHELL_OUT_W-1:0];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: record accepted beats, match delivered beats in order, check stall hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)
        exp_q.push_back(ref_prod(int'(in_log[MITCHELL_LOG_W-1:MITCHELL_FRAC_W]),
                                 int'(in_log[MITCHELL_FRAC_W-1:0]), in_zero));
      if (held_vld && out_valid) check("stall_hold", 32'(out_prod), 32'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
        else begin
          check("order_data", 32'(out_prod), 32'(exp_q.pop_front()));
          pops++;
        end
      end
      held_vld = out_valid && !out_ready;
      held     = out_prod;
    end else begin
      held_vld = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(int k, int f, bit z);
    bit acc;
    int b;
    b = 0;
    in_valid = 1'b1;
    in_log   = {k[MITCHELL_INT_W-1:0], f[MITCHELL_FRAC_W-1:0]};
    in_zero  = z;
    forever begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) break;
      b++;
      if (b > 200) begin
        n_cmp++; n_bad++;
        $error("FAIL send_timeout: observed no accept expected accept within 200 cycles");
        break;
      end
    end
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_prod", 32'(out_prod), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Case 1: k=0,f=0 -> 1, two-cycle latency, single-cycle valid
    out_ready = 1'b1;
    in_valid = 1'b1; in_log = '0; in_zero = 1'b0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_prod", 32'(out_prod), 32'd1);
    @(negedge clk);
    check("lat_one_cycle", 32'(out_valid), 32'd0);
    tick();

    // Cases 2-4: log3+log5, max, truncation/rounding, zero
    send(3, 96, 1'b0);
    send(15, 127, 1'b0);
    send(2, 127, 1'b0);
    send(15, 127, 1'b1);
    idle(4);
    check("zero_prod", 32'(out_prod), 32'd0);
    check("model_14", 32'(ref_prod(3, 96, 1'b0)), 32'd14);
    check("model_ff00", 32'(ref_prod(15, 127, 1'b0)), 32'hFF00);

    // Case 5: stall with both stages full
    out_ready = 1'b0;
    send(4, 10, 1'b0);
    send(5, 20, 1'b0);
    in_valid = 1'b1; in_log = {4'd6, 7'd30}; in_zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_prod", 32'(out_prod), 32'(ref_prod(4, 10, 1'b0)));
      tick();
    end
    out_ready = 1'b1;
    send(6, 30, 1'b0);
    send(7, 40, 1'b0);
    idle(5);
    check("stall_drained", exp_q.size(), 32'd0);

    // Case 6: reset with two beats in flight
    out_ready = 1'b0;
    send(8, 1, 1'b0);
    send(9, 2, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_prod", 32'(out_prod), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    tick();
    send(10, 5, 1'b0);
    idle(4);
    check("post_rst_drained", exp_q.size(), 32'd0);

    // Random stream with random back-pressure
    rand_rdy = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      else send($urandom_range(0, 15), $urandom_range(0, 127), ($urandom_range(0, 15) == 0));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(6);
    check("rand_drained", exp_q.size(), 32'd0);
    check("pops_nonzero", 32'(pops > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
